bin2bcd_funcmod: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the six-digit 7-segment scan stage. It converts a 20-bit unsigned binary value into six packed BCD digits (24 bits, most significant digit in [23:20]) using a shift-and-add-3 (double-dabble) loop, one iteration per clock. A call/done handshake starts each conversion. The result register feeds the scan stage's 24-bit data input and holds the previous result while a new conversion runs.

---
 rtl/bin2bcd_funcmod.sv | 132 +++++++++++++
 tb/tb_bin2bcd_funcmod.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_funcmod.sv
// Sequential 20-bit binary to six-digit packed BCD converter (double dabble, one bit per clock).
// Results above MAX_VAL saturate to 999999 and raise oOver; oData/oOver change only with oDone.
module bin2bcd_funcmod #(
  parameter int          N_BITS  = 20,
  parameter logic [19:0] MAX_VAL = 20'd999999
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              iCall,
  input  logic [N_BITS-1:0] iData,
  output logic              oDone,
  output logic              oBusy,
  output logic              oOver,
  output logic [23:0]       oData
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Each BCD digit of 5 or more gets 3 added, so the following shift carries into the next digit.
  function automatic logic [23:0] add3_all(input logic [23:0] v);
    logic [23:0] r;
    r = v;
    for (int i = 0; i < 6; i++) begin
      if (v[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   bin_q, bin_d;
  logic [23:0]         bcd_q, bcd_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [23:0]         data_q, data_d;
  logic                over_q, over_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [23:0]         adj_s;
  logic [N_BITS+23:0]  shift_s;

  // Next-state and datapath logic for the conversion sequencer.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    over_d  = over_q;
    done_d  = done_q;
    busy_d  = busy_q;
    adj_s   = add3_all(bcd_q);
    shift_s = {adj_s, bin_q} << 1;

    case (state_q)
      S_IDLE: begin
        if (iCall) begin
          bin_d   = iData;
          bcd_d   = 24'h000000;
          cnt_d   = 5'd0;
          ovf_d   = (iData > MAX_VAL);
          busy_d  = 1'b1;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        bcd_d = shift_s[N_BITS+23:N_BITS];
        bin_d = shift_s[N_BITS-1:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(N_BITS - 1)) begin
          data_d  = ovf_q ? 24'h999999 : shift_s[N_BITS+23:N_BITS];
          over_d  = ovf_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_CONV;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= 24'h000000;
      cnt_q   <= 5'd0;
      ovf_q   <= 1'b0;
      data_q  <= 24'h000000;
      over_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      over_q  <= over_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign oDone = done_q;
  assign oBusy = busy_q;
  assign oOver = over_q;
  assign oData = data_q;

endmodule

// File: tb/tb_bin2bcd_funcmod.sv
// Self-checking bench for bin2bcd_funcmod: directed corner cases plus random values
// compared against an arithmetic decimal-digit reference.
module tb_bin2bcd_funcmod;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        iCall = 1'b0;
  logic [19:0] iData = 20'd0;
  logic        oDone;
  logic        oBusy;
  logic        oOver;
  logic [23:0] oData;

  int          errors = 0;
  int          checks = 0;
  logic [23:0] prev_data = 24'h000000;
  logic        prev_over = 1'b0;

  bin2bcd_funcmod dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .iCall(iCall),
    .iData(iData),
    .oDone(oDone),
    .oBusy(oBusy),
    .oOver(oOver),
    .oData(oData)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, saturating above 999999.
  function automatic logic [23:0] ref_bcd(input logic [19:0] v);
    logic [23:0] r;
    int          x;
    r = 24'h000000;
    if (v > 20'd999999) begin
      r = 24'h999999;
    end else begin
      x = int'(v);
      for (int i = 0; i < 6; i++) begin
        r[i*4 +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // One full conversion; optionally re-pulses iCall with 7 so edge k+5 sees it.
  task automatic run_conv(input logic [19:0] v, input bit poke);
    logic [23:0] exp_d;
    logic        exp_o;
    int          done_at, done_cnt, busy_cnt, held_bad;
    exp_d = ref_bcd(v);
    exp_o = (v > 20'd999999);
    done_at = -1; done_cnt = 0; held_bad = 0;
    iCall = 1'b1;
    iData = v;
    tick();
    iCall = 1'b0;
    iData = 20'($urandom);
    busy_cnt = oBusy ? 1 : 0;
    for (int n = 1; n <= 23; n++) begin
      if (poke && n == 5) begin
        iCall = 1'b1;
        iData = 20'd7;
      end
      tick();
      if (poke && n == 5) iCall = 1'b0;
      if (oDone) begin
        done_cnt++;
        done_at = n;
      end
      if (oBusy) busy_cnt++;
      if (n < 20 && (oData !== prev_data || oOver !== prev_over)) held_bad++;
    end
    check("done_latency", done_at, 20);
    check("done_count", done_cnt, 1);
    check("busy_cycles", busy_cnt, 21);
    check("held_before_done", held_bad, 0);
    check("data", {8'h00, oData}, {8'h00, exp_d});
    check("over", {31'd0, oOver}, {31'd0, exp_o});
    prev_data = exp_d;
    prev_over = exp_o;
  endtask

  initial begin
    int dones [$];
    int cnt;
    logic [19:0] rv;

    tick();
    tick();
    RESET = 1'b0;
    check("rst_data", {8'h00, oData}, 32'h0);
    check("rst_done", {31'd0, oDone}, 32'h0);
    check("rst_busy", {31'd0, oBusy}, 32'h0);
    check("rst_over", {31'd0, oOver}, 32'h0);

    run_conv(20'd0, 1'b0);
    run_conv(20'd123456, 1'b0);
    run_conv(20'd999999, 1'b0);
    run_conv(20'd9, 1'b0);
    run_conv(20'd1000000, 1'b0);
    run_conv(20'hFFFFF, 1'b0);
    run_conv(20'd42, 1'b0);
    run_conv(20'd500000, 1'b1);

    // Continuous iCall: starts at k, k+22, k+44; dropped before k+66.
    iCall = 1'b1;
    iData = 20'd314159;
    tick();
    cnt = 0;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (n == 65) iCall = 1'b0;
      if (oDone) begin
        dones.push_back(n);
        if (oData !== 24'h314159) cnt++;
      end
    end
    check("b2b_count", dones.size(), 3);
    if (dones.size() == 3) begin
      check("b2b_done0", dones[0], 20);
      check("b2b_done1", dones[1], 42);
      check("b2b_done2", dones[2], 64);
    end
    check("b2b_data_bad", cnt, 0);
    prev_data = 24'h314159;
    prev_over = 1'b0;

    run_conv(20'd1048575, 1'b0);

    // Reset at edge k+10 aborts a conversion.
    iCall = 1'b1;
    iData = 20'd777777;
    tick();
    iCall = 1'b0;
    repeat (9) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("abort_data", {8'h00, oData}, 32'h0);
    check("abort_busy", {31'd0, oBusy}, 32'h0);
    check("abort_over", {31'd0, oOver}, 32'h0);
    check("abort_done", {31'd0, oDone}, 32'h0);
    cnt = 0;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (oDone) cnt++;
    end
    check("abort_no_done", cnt, 0);
    prev_data = 24'h000000;
    prev_over = 1'b0;
    run_conv(20'd777777, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rv = (i % 5 == 4) ? 20'($urandom_range(1000000, 1048575))
                        : 20'($urandom_range(0, 999999));
      run_conv(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
